// File: rtl/uart_rx_controller.sv
// Sequencer for one UartRx receiver: captures and acknowledges each byte, buffers it in a
// first-word-fall-through FIFO, and applies divider/parity updates only between bytes.
module uart_rx_controller #(
   parameter int CLOCK_DIVIDER_WIDTH = 16,
   parameter int DEFAULT_DIVIDER     = 16,
   parameter int FIFO_ADDR_WIDTH     = 3
) (
   input  logic                           clock_i,
   input  logic                           reset_i,
   input  logic                           config_write_i,
   input  logic [CLOCK_DIVIDER_WIDTH-1:0] config_divider_i,
   input  logic                           config_parity_bit_i,
   input  logic                           config_parity_even_i,
   input  logic [7:0]                     rx_data_i,
   input  logic                           rx_ready_i,
   output logic                           rx_clear_ready_o,
   output logic                           rx_reset_o,
   output logic [CLOCK_DIVIDER_WIDTH-1:0] rx_clock_divider_o,
   output logic                           rx_parity_bit_o,
   output logic                           rx_parity_even_o,
   output logic [7:0]                     data_o,
   output logic                           valid_o,
   input  logic                           ready_i,
   output logic [FIFO_ADDR_WIDTH:0]       fill_o,
   output logic                           overrun_o,
   input  logic                           overrun_clear_i
);

   localparam int DEPTH = 2 ** FIFO_ADDR_WIDTH;
   localparam logic [FIFO_ADDR_WIDTH:0]       FILL_FULL   = (FIFO_ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [CLOCK_DIVIDER_WIDTH-1:0] DIVIDER_RST = CLOCK_DIVIDER_WIDTH'(DEFAULT_DIVIDER);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_CLEAR,
      ST_WAIT_LOW,
      ST_RECONFIG
   } state_t;

   state_t                           r_state;
   logic                             r_reconfig_cnt;
   logic                             r_clear_ready;
   logic                             r_rx_reset;
   logic [CLOCK_DIVIDER_WIDTH-1:0]   r_divider;
   logic                             r_parity_bit;
   logic                             r_parity_even;

   logic                             r_pend_valid;
   logic [CLOCK_DIVIDER_WIDTH-1:0]   r_pend_divider;
   logic                             r_pend_parity_bit;
   logic                             r_pend_parity_even;

   logic [7:0]                       r_mem [DEPTH];
   logic [FIFO_ADDR_WIDTH-1:0]       r_wr_ptr;
   logic [FIFO_ADDR_WIDTH-1:0]       r_rd_ptr;
   logic [FIFO_ADDR_WIDTH:0]         r_count;
   logic                             r_overrun;

   logic                             w_full;
   logic                             w_valid;
   logic                             w_pop;
   logic                             w_push;
   logic                             w_drop;
   logic                             w_cfg_apply;

   assign w_full      = (r_count == FILL_FULL);
   assign w_valid     = (r_count != '0);
   assign w_pop       = w_valid && ready_i;
   // A pop in the capture cycle frees a slot, so a full FIFO can still accept the byte.
   assign w_push      = (r_state == ST_CAPTURE) && (!w_full || w_pop);
   assign w_drop      = (r_state == ST_CAPTURE) && w_full && !w_pop;
   assign w_cfg_apply = (r_state == ST_IDLE) && r_pend_valid;

   // Pending flag is consumed on RECONFIG entry, so any write landing during RECONFIG
   // (including its last cycle) stays pending for the next pass through IDLE.
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         r_pend_valid       <= 1'b0;
         r_pend_divider     <= DIVIDER_RST;
         r_pend_parity_bit  <= 1'b0;
         r_pend_parity_even <= 1'b0;
      end else if (config_write_i) begin
         r_pend_valid       <= 1'b1;
         r_pend_divider     <= config_divider_i;
         r_pend_parity_bit  <= config_parity_bit_i;
         r_pend_parity_even <= config_parity_even_i;
      end else if (w_cfg_apply) begin
         r_pend_valid       <= 1'b0;
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every register samples
   // the pre-edge value of its inputs regardless of block ordering.
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         r_state        <= ST_IDLE;
         r_reconfig_cnt <= 1'b0;
         r_clear_ready  <= 1'b0;
         r_rx_reset     <= 1'b0;
         r_divider      <= DIVIDER_RST;
         r_parity_bit   <= 1'b0;
         r_parity_even  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (r_pend_valid) begin
                  r_state        <= ST_RECONFIG;
                  r_reconfig_cnt <= 1'b0;
                  r_rx_reset     <= 1'b1;
                  r_divider      <= r_pend_divider;
                  r_parity_bit   <= r_pend_parity_bit;
                  r_parity_even  <= r_pend_parity_even;
               end else if (rx_ready_i) begin
                  r_state <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               r_state       <= ST_CLEAR;
               r_clear_ready <= 1'b1;
            end
            ST_CLEAR: begin
               r_state       <= ST_WAIT_LOW;
               r_clear_ready <= 1'b0;
            end
            ST_WAIT_LOW: begin
               // Waiting for ready to drop guarantees a single capture per received byte.
               if (!rx_ready_i) begin
                  r_state <= ST_IDLE;
               end
            end
            ST_RECONFIG: begin
               if (r_reconfig_cnt) begin
                  r_state    <= ST_IDLE;
                  r_rx_reset <= 1'b0;
               end else begin
                  r_reconfig_cnt <= 1'b1;
               end
            end
            default: begin
               r_state       <= ST_IDLE;
               r_clear_ready <= 1'b0;
               r_rx_reset    <= 1'b0;
            end
         endcase
      end
   end

   // NOTE: the storage array has no reset; the pointers and count define what is valid,
   // and leaving the data unreset lets it map onto plain RAM/flop arrays.
   always_ff @(posedge clock_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= rx_data_i;
      end
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_drop) begin
            r_overrun <= 1'b1;
         end else if (overrun_clear_i) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign rx_clear_ready_o   = r_clear_ready;
   assign rx_reset_o         = r_rx_reset;
   assign rx_clock_divider_o = r_divider;
   assign rx_parity_bit_o    = r_parity_bit;
   assign rx_parity_even_o   = r_parity_even;
   assign data_o             = r_mem[r_rd_ptr];
   assign valid_o            = w_valid;
   assign fill_o             = r_count;
   assign overrun_o          = r_overrun;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller; the UartRx side is emulated by driving ready/data
// and dropping ready once clear_ready is seen.
module tb_uart_rx_controller;

   logic        clock_i = 1'b0;
   logic        reset_i = 1'b0;
   logic        config_write_i = 1'b0;
   logic [15:0] config_divider_i = '0;
   logic        config_parity_bit_i = 1'b0;
   logic        config_parity_even_i = 1'b0;
   logic [7:0]  rx_data_i = '0;
   logic        rx_ready_i = 1'b0;
   logic        rx_clear_ready_o;
   logic        rx_reset_o;
   logic [15:0] rx_clock_divider_o;
   logic        rx_parity_bit_o;
   logic        rx_parity_even_o;
   logic [7:0]  data_o;
   logic        valid_o;
   logic        ready_i = 1'b0;
   logic [3:0]  fill_o;
   logic        overrun_o;
   logic        overrun_clear_i = 1'b0;

   int n_pass  = 0;
   int n_total = 0;

   uart_rx_controller #(
      .CLOCK_DIVIDER_WIDTH (16),
      .DEFAULT_DIVIDER     (16),
      .FIFO_ADDR_WIDTH     (3)
   ) dut (
      .clock_i              (clock_i),
      .reset_i              (reset_i),
      .config_write_i       (config_write_i),
      .config_divider_i     (config_divider_i),
      .config_parity_bit_i  (config_parity_bit_i),
      .config_parity_even_i (config_parity_even_i),
      .rx_data_i            (rx_data_i),
      .rx_ready_i           (rx_ready_i),
      .rx_clear_ready_o     (rx_clear_ready_o),
      .rx_reset_o           (rx_reset_o),
      .rx_clock_divider_o   (rx_clock_divider_o),
      .rx_parity_bit_o      (rx_parity_bit_o),
      .rx_parity_even_o     (rx_parity_even_o),
      .data_o               (data_o),
      .valid_o              (valid_o),
      .ready_i              (ready_i),
      .fill_o               (fill_o),
      .overrun_o            (overrun_o),
      .overrun_clear_i      (overrun_clear_i)
   );

   always #5 clock_i = ~clock_i;

   // Emulated UartRx: present a byte, drop ready when clear_ready is seen; counts clear pulses.
   task automatic send_byte(input logic [7:0] b, output int pulses);
      pulses = 0;
      @(negedge clock_i);
      rx_data_i  = b;
      rx_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock_i);
         if (rx_clear_ready_o === 1'b1) begin
            pulses++;
            rx_ready_i = 1'b0;
         end
      end
      rx_ready_i = 1'b0;
   endtask

   task automatic pop_one();
      @(negedge clock_i);
      ready_i = 1'b1;
      @(negedge clock_i);
      ready_i = 1'b0;
   endtask

   task automatic cfg_write(input logic [15:0] div, input logic pb, input logic pe);
      @(negedge clock_i);
      config_divider_i     = div;
      config_parity_bit_i  = pb;
      config_parity_even_i = pe;
      config_write_i       = 1'b1;
      @(negedge clock_i);
      config_write_i       = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock_i);
      n_total++;
      if (valid_o !== 1'b0 || fill_o !== 4'd0 || overrun_o !== 1'b0) begin
         $display("FAIL reset_fifo: valid=%b fill=%0d overrun=%b, want 0/0/0", valid_o, fill_o, overrun_o);
      end else n_pass++;
      n_total++;
      if (rx_clear_ready_o !== 1'b0 || rx_reset_o !== 1'b0 || rx_clock_divider_o !== 16'd16 ||
          rx_parity_bit_o !== 1'b0 || rx_parity_even_o !== 1'b0) begin
         $display("FAIL reset_rx_cfg: clr=%b rst=%b div=%0d pb=%b pe=%b, want 0/0/16/0/0",
                  rx_clear_ready_o, rx_reset_o, rx_clock_divider_o, rx_parity_bit_o, rx_parity_even_o);
      end else n_pass++;
      reset_i = 1'b1;
      repeat (2) @(negedge clock_i);
      n_total++;
      if (valid_o !== 1'b0 || rx_reset_o !== 1'b0) begin
         $display("FAIL reset_release: valid=%b rx_reset=%b, want 0/0", valid_o, rx_reset_o);
      end else n_pass++;
   endtask

   task automatic test_single_byte();
      int pulses;
      cfg_write(16'd8, 1'b0, 1'b0);
      repeat (4) @(negedge clock_i);
      n_total++;
      if (rx_clock_divider_o !== 16'd8) begin
         $display("FAIL single_divider: got %0d want 8", rx_clock_divider_o);
      end else n_pass++;
      send_byte(8'h55, pulses);
      n_total++;
      if (valid_o !== 1'b1 || data_o !== 8'h55) begin
         $display("FAIL single_data: valid=%b data=%h, want 1/55", valid_o, data_o);
      end else n_pass++;
      n_total++;
      if (pulses !== 1) begin
         $display("FAIL single_clear_pulses: got %0d want 1", pulses);
      end else n_pass++;
      n_total++;
      if (fill_o !== 4'd1) begin
         $display("FAIL single_fill: got %0d want 1", fill_o);
      end else n_pass++;
      pop_one();
      n_total++;
      if (valid_o !== 1'b0 || fill_o !== 4'd0) begin
         $display("FAIL single_pop: valid=%b fill=%0d, want 0/0", valid_o, fill_o);
      end else n_pass++;
   endtask

   task automatic test_fill_overrun();
      int pulses;
      for (int i = 0; i < 8; i++) begin
         send_byte(8'(i), pulses);
      end
      n_total++;
      if (fill_o !== 4'd8 || overrun_o !== 1'b0) begin
         $display("FAIL fill_full: fill=%0d overrun=%b, want 8/0", fill_o, overrun_o);
      end else n_pass++;
      send_byte(8'hAA, pulses);
      n_total++;
      if (fill_o !== 4'd8 || overrun_o !== 1'b1) begin
         $display("FAIL fill_overrun: fill=%0d overrun=%b, want 8/1", fill_o, overrun_o);
      end else n_pass++;
      n_total++;
      if (pulses !== 1) begin
         $display("FAIL fill_drop_clear: got %0d pulses want 1", pulses);
      end else n_pass++;
      for (int i = 0; i < 8; i++) begin
         n_total++;
         if (valid_o !== 1'b1 || data_o !== 8'(i)) begin
            $display("FAIL fill_drain[%0d]: valid=%b data=%h, want 1/%h", i, valid_o, data_o, 8'(i));
         end else n_pass++;
         pop_one();
      end
      n_total++;
      if (valid_o !== 1'b0 || fill_o !== 4'd0 || overrun_o !== 1'b1) begin
         $display("FAIL fill_drained: valid=%b fill=%0d overrun=%b, want 0/0/1", valid_o, fill_o, overrun_o);
      end else n_pass++;
      @(negedge clock_i);
      overrun_clear_i = 1'b1;
      @(negedge clock_i);
      overrun_clear_i = 1'b0;
      n_total++;
      if (overrun_o !== 1'b0) begin
         $display("FAIL overrun_clear: got %b want 0", overrun_o);
      end else n_pass++;
   endtask

   task automatic test_full_pop_same_cycle();
      int pulses;
      logic [7:0] exp;
      for (int i = 0; i < 8; i++) begin
         send_byte(8'h10 + 8'(i), pulses);
      end
      @(negedge clock_i);
      rx_data_i  = 8'hC3;
      rx_ready_i = 1'b1;
      @(negedge clock_i);
      ready_i = 1'b1;
      @(negedge clock_i);
      ready_i = 1'b0;
      n_total++;
      if (rx_clear_ready_o !== 1'b1) begin
         $display("FAIL fullpop_clear: got %b want 1", rx_clear_ready_o);
      end else n_pass++;
      rx_ready_i = 1'b0;
      repeat (3) @(negedge clock_i);
      n_total++;
      if (fill_o !== 4'd8 || overrun_o !== 1'b0) begin
         $display("FAIL fullpop_state: fill=%0d overrun=%b, want 8/0", fill_o, overrun_o);
      end else n_pass++;
      for (int i = 0; i < 8; i++) begin
         exp = (i < 7) ? (8'h11 + 8'(i)) : 8'hC3;
         n_total++;
         if (valid_o !== 1'b1 || data_o !== exp) begin
            $display("FAIL fullpop_drain[%0d]: valid=%b data=%h, want 1/%h", i, valid_o, data_o, exp);
         end else n_pass++;
         pop_one();
      end
      n_total++;
      if (valid_o !== 1'b0) begin
         $display("FAIL fullpop_empty: valid=%b want 0", valid_o);
      end else n_pass++;
   endtask

   task automatic test_reconfig();
      int pulses;
      int hi;
      logic [15:0] div_seen;
      logic pb_seen, pe_seen;
      hi = 0;
      div_seen = '0;
      pb_seen = 1'b0;
      pe_seen = 1'b0;
      @(negedge clock_i);
      rx_data_i  = 8'h3C;
      rx_ready_i = 1'b1;
      @(negedge clock_i);
      config_divider_i     = 16'd4;
      config_parity_bit_i  = 1'b1;
      config_parity_even_i = 1'b1;
      config_write_i       = 1'b1;
      @(negedge clock_i);
      config_write_i = 1'b0;
      repeat (3) @(negedge clock_i);
      n_total++;
      if (rx_reset_o !== 1'b0 || rx_clock_divider_o !== 16'd8) begin
         $display("FAIL reconfig_held: rx_reset=%b div=%0d, want 0/8 during WAIT_LOW", rx_reset_o, rx_clock_divider_o);
      end else n_pass++;
      rx_ready_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock_i);
         if (rx_reset_o === 1'b1) begin
            if (hi == 0) begin
               div_seen = rx_clock_divider_o;
               pb_seen  = rx_parity_bit_o;
               pe_seen  = rx_parity_even_o;
            end
            hi++;
         end
      end
      n_total++;
      if (hi !== 2) begin
         $display("FAIL reconfig_reset_len: got %0d cycles want 2", hi);
      end else n_pass++;
      n_total++;
      if (div_seen !== 16'd4 || pb_seen !== 1'b1 || pe_seen !== 1'b1) begin
         $display("FAIL reconfig_values: div=%0d pb=%b pe=%b, want 4/1/1", div_seen, pb_seen, pe_seen);
      end else n_pass++;
      send_byte(8'h99, pulses);
      n_total++;
      if (fill_o !== 4'd2 || data_o !== 8'h3C) begin
         $display("FAIL reconfig_fifo: fill=%0d head=%h, want 2/3c", fill_o, data_o);
      end else n_pass++;
      pop_one();
      n_total++;
      if (valid_o !== 1'b1 || data_o !== 8'h99) begin
         $display("FAIL reconfig_next_byte: valid=%b data=%h, want 1/99", valid_o, data_o);
      end else n_pass++;
      pop_one();
   endtask

   task automatic test_double_config();
      int hi, rises;
      logic prev;
      hi = 0;
      rises = 0;
      prev = 1'b0;
      @(negedge clock_i);
      rx_data_i  = 8'h5A;
      rx_ready_i = 1'b1;
      repeat (2) @(negedge clock_i);
      cfg_write(16'd6, 1'b0, 1'b0);
      cfg_write(16'd10, 1'b0, 1'b0);
      @(negedge clock_i);
      rx_ready_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock_i);
         if (rx_reset_o === 1'b1) begin
            hi++;
            if (!prev) rises++;
         end
         prev = rx_reset_o;
      end
      n_total++;
      if (rises !== 1 || hi !== 2) begin
         $display("FAIL double_cfg_single_reconfig: rises=%0d cycles=%0d, want 1/2", rises, hi);
      end else n_pass++;
      n_total++;
      if (rx_clock_divider_o !== 16'd10 || rx_parity_bit_o !== 1'b0) begin
         $display("FAIL double_cfg_last_wins: div=%0d pb=%b, want 10/0", rx_clock_divider_o, rx_parity_bit_o);
      end else n_pass++;
      n_total++;
      if (valid_o !== 1'b1 || data_o !== 8'h5A) begin
         $display("FAIL double_cfg_byte: valid=%b data=%h, want 1/5a", valid_o, data_o);
      end else n_pass++;
      pop_one();
   endtask

   task automatic test_async_reset();
      int pulses;
      for (int i = 0; i < 9; i++) begin
         send_byte(8'h20 + 8'(i), pulses);
      end
      for (int i = 0; i < 5; i++) begin
         pop_one();
      end
      n_total++;
      if (fill_o !== 4'd3 || overrun_o !== 1'b1) begin
         $display("FAIL areset_pre: fill=%0d overrun=%b, want 3/1", fill_o, overrun_o);
      end else n_pass++;
      @(negedge clock_i);
      rx_data_i  = 8'h77;
      rx_ready_i = 1'b1;
      #2;
      reset_i = 1'b0;
      #1;
      n_total++;
      if (valid_o !== 1'b0 || fill_o !== 4'd0 || overrun_o !== 1'b0) begin
         $display("FAIL areset_fifo: valid=%b fill=%0d overrun=%b, want 0/0/0", valid_o, fill_o, overrun_o);
      end else n_pass++;
      n_total++;
      if (rx_clear_ready_o !== 1'b0 || rx_reset_o !== 1'b0 || rx_clock_divider_o !== 16'd16 ||
          rx_parity_bit_o !== 1'b0 || rx_parity_even_o !== 1'b0) begin
         $display("FAIL areset_rx_cfg: clr=%b rst=%b div=%0d pb=%b pe=%b, want 0/0/16/0/0",
                  rx_clear_ready_o, rx_reset_o, rx_clock_divider_o, rx_parity_bit_o, rx_parity_even_o);
      end else n_pass++;
      rx_ready_i = 1'b0;
      @(negedge clock_i);
      reset_i = 1'b1;
      repeat (3) @(negedge clock_i);
      n_total++;
      if (valid_o !== 1'b0 || rx_reset_o !== 1'b0) begin
         $display("FAIL areset_after: valid=%b rx_reset=%b, want 0/0", valid_o, rx_reset_o);
      end else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_fill_overrun();
      test_full_pop_same_cycle();
      test_reconfig();
      test_double_config();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
